mynios2_timer_multi: RTL and testbench
======================================

# mynios2_timer_multi

Parametrised multi-channel interval timer on the Nios II Avalon-MM bus: a generalisation of the single-channel system timer. NUM_CH independent down-counters of width COUNT_W, each with its own period, snapshot, status/control, optional clock prescaler and interrupt. It drives a combined CPU IRQ plus a per-channel IRQ vector for other fabric consumers.

## Interface
- NUM_CH, 4, channel count, 1..8
- COUNT_W, 32, counter and period width, 17..32
- DEFAULT_PERIOD, 49999, reset value of every period and counter
- ADDR_W, 3+clog2(NUM_CH) (3 when NUM_CH=1), derived, not overridden
- clk  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- chipselect  in  1  Avalon slave select
- address  in  ADDR_W  [ADDR_W-1:3] channel, [2:0] register offset
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data; reset 0
- irq  out  1  OR of all irq_vec bits; reset 0
- irq_vec  out  NUM_CH  per-channel TO & ITO; reset 0

## Operation
- Write = chipselect & ~write_n. A channel index >= NUM_CH reads 0 and ignores writes.
- Per-channel offsets:
  - 0 status: bit0 TO, bit1 RUN. Any write clears TO. RUN is read-only.
  - 1 control: bit0 ITO, bit1 CONT stored. bit2 START and bit3 STOP are action-only; reads return {14'b0,CONT,ITO}.
  - 2/3 period_l/period_h: bits of period_h at or above COUNT_W-16 are ignored on write and read 0.
  - 4/5 snap_l/snap_h: any write to either latches the whole counter into snapshot; reads return the snapshot halves.
  - 6 prescale: PS register (macro-dependent). 7: reserved, reads 0.
- Tick: every clock without the macro; with the macro, one clock in every PS+1.
- Running channel on a tick:
  - Counter != 0: decrement.
  - Counter == 0 (the zero tick): counter <= period, TO <= 1, RUN <= CONT.
  - Period 0 with CONT=1 gives a timeout every tick.
- Period write (either half): RUN cleared that edge. Next cycle force_reload loads counter <= {period_h,period_l} and resets the prescale count. The channel stays stopped until START.
- START: RUN <= 1 and prescale count reset. Counter value unchanged.
- STOP: RUN <= 0. Counter holds its value.
- Reset: all channels have period = counter = DEFAULT_PERIOD, snapshot 0, control 0, TO 0, RUN 0, PS 0.

## Timing
- readdata is registered from the current address every cycle, regardless of chipselect: 1-cycle read latency.
- Register writes take effect at the write edge. Control effects are visible on the next cycle.
- Channel started with counter = P and PS = 0: zero tick on the P+1-th clock edge after START; TO and irq_vec are high from that edge.
- With PS = k: the zero tick occurs (P+1)(k+1) clocks after START.
- irq and irq_vec are combinational from TO & ITO. No added latency.
- Simultaneous events:
  - Status write and zero tick in the same cycle: clear wins, TO = 0.
  - START and STOP written together: START wins.
  - Period write and START in the same cycle are impossible (different offsets).
  - Snap write during a decrement: captures the pre-decrement value.
- Asynchronous reset mid-count returns all state to reset values immediately. readdata is 0.

## Configuration
- TIMER_PRESCALER_EN defined:
  - Offset 6 per channel is a 16-bit R/W PS register, plus a 16-bit prescale counter per channel.
  - Tick when the prescale count == PS, then the count returns to 0.
- Undefined:
  - No prescaler logic; offset 6 reads 0 and writes are ignored.
  - Tick every clock, so behaviour matches a 1-cycle timebase.

## Test plan
- Reset, then read ch0 offsets 2/3 → 0xC34F / 0x0000. Read offset 0 → 0x0000. irq = 0.
- ch1: period = 5, CONT = 0, ITO = 1, START → TO and irq_vec[1] rise 6 clocks after START. RUN drops. Counter reloads 5. irq = 1. Status write → irq = 0.
- ch2: period = 3, CONT = 1, ITO = 0, START → TO set every 4 clocks (sticky). irq stays 0. Clearing status in the same cycle as a zero tick leaves TO = 0.
- ch0 running from 0x10000: write snap_l → snap_h/snap_l read the pre-write-edge counter value. Period write mid-count → RUN = 0 and counter = new period one cycle later.
- With TIMER_PRESCALER_EN, ch3: PS = 2, period = 1, START → TO after 6 clocks. Without the macro, offset 6 reads 0 after writing 0xFFFF.
- NUM_CH = 3: write to channel 3 offset 2, then read it → 0. Channels 0-2 unchanged.

Source files
------------

// File: rtl/mynios2_timer_multi.sv
// rtl/mynios2_timer_multi.sv - NUM_CH-channel Avalon-MM interval timer; optional prescaler via TIMER_PRESCALER_EN
module mynios2_timer_multi #(
    parameter  int          NUM_CH         = 4,
    parameter  int          COUNT_W        = 32,
    parameter  int unsigned DEFAULT_PERIOD = 49999,
    localparam int          ADDR_W         = (NUM_CH > 1) ? 3 + $clog2(NUM_CH) : 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0] ch_idx;
    logic [2:0]      offset;
    logic            ch_valid;
    logic            wr_en;
    logic [15:0]     rd_ch [NUM_CH];
    logic [15:0]     rd_mux;

    if (NUM_CH > 1) begin : g_idx
        assign ch_idx = address[ADDR_W-1:3];
    end else begin : g_idx_single
        assign ch_idx = '0;
    end

    assign offset   = address[2:0];
    assign ch_valid = 32'(ch_idx) < 32'(NUM_CH);
    assign wr_en    = chipselect & ~write_n;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [COUNT_W-1:0] period_q;
        logic [COUNT_W-1:0] counter_q;
        logic [COUNT_W-1:0] snap_q;
        logic               ito_q, cont_q, to_q, run_q, reload_q;
        logic               sel, wr, tick;
        logic [31:0]        period_ext, snap_ext;
        logic [15:0]        ps_rd;

        assign sel        = ch_valid && (ch_idx == CH_W'(c));
        assign wr         = wr_en && sel;
        assign period_ext = 32'(period_q);
        assign snap_ext   = 32'(snap_q);

`ifdef TIMER_PRESCALER_EN
        logic [15:0] ps_q, pscnt_q;

        assign tick  = run_q && (pscnt_q == ps_q);
        assign ps_rd = ps_q;

        // Prescale divider: restarts on START or reload, wraps to 0 on each tick
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ps_q    <= 16'd0;
                pscnt_q <= 16'd0;
            end else begin
                if (wr && offset == 3'd6) ps_q <= writedata;
                if (reload_q || (wr && offset == 3'd1 && writedata[2])) pscnt_q <= 16'd0;
                else if (run_q) pscnt_q <= tick ? 16'd0 : pscnt_q + 16'd1;
            end
        end
`else
        assign tick  = run_q;
        assign ps_rd = 16'd0;
`endif

        // Channel state: count/reload first, register writes after so clear, START and period writes win
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                period_q  <= COUNT_W'(DEFAULT_PERIOD);
                counter_q <= COUNT_W'(DEFAULT_PERIOD);
                snap_q    <= '0;
                ito_q     <= 1'b0;
                cont_q    <= 1'b0;
                to_q      <= 1'b0;
                run_q     <= 1'b0;
                reload_q  <= 1'b0;
            end else begin
                reload_q <= 1'b0;
                if (reload_q) begin
                    counter_q <= period_q;
                end else if (tick) begin
                    if (counter_q == '0) begin
                        counter_q <= period_q;
                        to_q      <= 1'b1;
                        run_q     <= cont_q;
                    end else begin
                        counter_q <= counter_q - COUNT_W'(1);
                    end
                end
                if (wr) begin
                    case (offset)
                        3'd0: to_q <= 1'b0;
                        3'd1: begin
                            ito_q  <= writedata[0];
                            cont_q <= writedata[1];
                            if (writedata[2])      run_q <= 1'b1;
                            else if (writedata[3]) run_q <= 1'b0;
                        end
                        3'd2: begin
                            period_q[15:0] <= writedata;
                            run_q          <= 1'b0;
                            reload_q       <= 1'b1;
                        end
                        3'd3: begin
                            period_q[COUNT_W-1:16] <= writedata[COUNT_W-17:0];
                            run_q                  <= 1'b0;
                            reload_q               <= 1'b1;
                        end
                        3'd4, 3'd5: snap_q <= counter_q;
                        default: ;
                    endcase
                end
            end
        end

        // Per-channel read value, zero unless this channel is addressed
        always_comb begin
            rd_ch[c] = 16'd0;
            if (sel) begin
                case (offset)
                    3'd0:    rd_ch[c] = {14'd0, run_q, to_q};
                    3'd1:    rd_ch[c] = {14'd0, cont_q, ito_q};
                    3'd2:    rd_ch[c] = period_ext[15:0];
                    3'd3:    rd_ch[c] = period_ext[31:16];
                    3'd4:    rd_ch[c] = snap_ext[15:0];
                    3'd5:    rd_ch[c] = snap_ext[31:16];
                    3'd6:    rd_ch[c] = ps_rd;
                    default: rd_ch[c] = 16'd0;
                endcase
            end
        end

        assign irq_vec[c] = to_q & ito_q;
    end

    // Only one channel drives a nonzero value, so OR-ing them forms the mux
    always_comb begin
        rd_mux = 16'd0;
        for (int i = 0; i < NUM_CH; i++) rd_mux = rd_mux | rd_ch[i];
    end

    // Read data registered from the current address every cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= 16'd0;
        else          readdata <= rd_mux;
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_mynios2_timer_multi.sv
// tb/tb_mynios2_timer_multi.sv - self-checking bench for mynios2_timer_multi
module tb_mynios2_timer_multi;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        cs3 = 1'b0;
    logic [4:0]  address = '0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata, readdata3;
    logic        irq, irq3;
    logic [3:0]  irq_vec;
    logic [2:0]  irq_vec3;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string       nm;
        logic [15:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    always #5 clk = ~clk;

    mynios2_timer_multi dut (
        .clk(clk), .reset_n(reset_n), .chipselect(cs), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .irq_vec(irq_vec)
    );

    mynios2_timer_multi #(.NUM_CH(3)) u3 (
        .clk(clk), .reset_n(reset_n), .chipselect(cs3), .address(address),
        .write_n(write_n), .writedata(writedata), .readdata(readdata3),
        .irq(irq3), .irq_vec(irq_vec3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input bit u, input logic [1:0] ch, input logic [2:0] off, input logic [15:0] d);
        @(negedge clk);
        address   = {ch, off};
        writedata = d;
        write_n   = 1'b0;
        if (u) cs3 = 1'b1;
        else   cs  = 1'b1;
        @(negedge clk);
        cs      = 1'b0;
        cs3     = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic rd(input bit u, input logic [4:0] a, input logic [15:0] exp, input string nm);
        sb_t e;
        @(negedge clk);
        address = a;
        sb_q.push_back('{nm, exp});
        @(negedge clk);
        e = sb_q.pop_front();
        chk(e.nm, u ? readdata3 : readdata, e.exp);
    endtask

    task automatic measure_rise(input int b, input int exp, input string nm);
        int n;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (irq_vec[b]) begin
                n = i;
                break;
            end
        end
        chk(nm, n, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   first;
        bit   irq_bad;

        vecs[0] = '{5'b00_010, 16'hC34F, "rst ch0 period_l"};
        vecs[1] = '{5'b00_011, 16'h0000, "rst ch0 period_h"};
        vecs[2] = '{5'b00_000, 16'h0000, "rst ch0 status"};
        vecs[3] = '{5'b00_001, 16'h0000, "rst ch0 control"};
        vecs[4] = '{5'b00_100, 16'h0000, "rst ch0 snap_l"};
        vecs[5] = '{5'b00_101, 16'h0000, "rst ch0 snap_h"};
        vecs[6] = '{5'b00_111, 16'h0000, "rst ch0 reserved"};
        vecs[7] = '{5'b11_010, 16'hC34F, "rst ch3 period_l"};

        repeat (3) @(negedge clk);
        chk("readdata in reset", readdata, 16'h0000);
        chk("irq in reset", irq, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) rd(0, vecs[i].addr, vecs[i].exp, vecs[i].nm);
        chk("irq after reset", irq, 1'b0);
        chk("irq_vec after reset", irq_vec, 4'h0);

        // ch1 one-shot with interrupt enabled
        wr(0, 2'd1, 3'd2, 16'd5);
        wr(0, 2'd1, 3'd3, 16'd0);
        wr(0, 2'd1, 3'd1, 16'h0005);
        measure_rise(1, 6, "ch1 timeout latency");
        chk("ch1 irq", irq, 1'b1);
        rd(0, 5'b01_000, 16'h0001, "ch1 status after one-shot");
        wr(0, 2'd1, 3'd4, 16'd0);
        rd(0, 5'b01_100, 16'd5, "ch1 counter reloaded");
        wr(0, 2'd1, 3'd0, 16'd0);
        chk("ch1 irq after status clear", irq, 1'b0);
        chk("irq_vec after status clear", irq_vec, 4'h0);

        // ch2 continuous, no interrupt; clear collides with a zero tick
        wr(0, 2'd2, 3'd2, 16'd3);
        wr(0, 2'd2, 3'd3, 16'd0);
        wr(0, 2'd2, 3'd1, 16'h0006);
        address = 5'b10_000;
        first   = -1;
        irq_bad = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (irq) irq_bad = 1'b1;
            if (readdata[0] && first < 0) first = i - 1;
        end
        chk("ch2 first timeout edge", first, 4);
        repeat (6) begin
            @(negedge clk);
            if (irq) irq_bad = 1'b1;
        end
        cs        = 1'b1;
        write_n   = 1'b0;
        writedata = 16'd0;
        @(negedge clk);
        cs      = 1'b0;
        write_n = 1'b1;
        @(negedge clk);
        chk("ch2 clear wins over zero tick", readdata, 16'h0002);
        repeat (4) begin
            @(negedge clk);
            if (irq) irq_bad = 1'b1;
        end
        chk("ch2 next periodic timeout", readdata, 16'h0003);
        chk("ch2 irq stayed low", irq_bad, 1'b0);
        wr(0, 2'd2, 3'd1, 16'h0008);

        // ch0 snapshot and mid-count period write
        wr(0, 2'd0, 3'd2, 16'h0000);
        wr(0, 2'd0, 3'd3, 16'h0001);
        wr(0, 2'd0, 3'd1, 16'h0004);
        repeat (3) @(negedge clk);
        wr(0, 2'd0, 3'd4, 16'd0);
        rd(0, 5'b00_101, 16'h0000, "ch0 snap_h");
        rd(0, 5'b00_100, 16'hFFFC, "ch0 snap_l pre-decrement");
        rd(0, 5'b00_000, 16'h0002, "ch0 running");
        wr(0, 2'd0, 3'd2, 16'h0100);
        rd(0, 5'b00_000, 16'h0000, "ch0 stopped by period write");
        wr(0, 2'd0, 3'd5, 16'd0);
        rd(0, 5'b00_100, 16'h0100, "ch0 reload snap_l");
        rd(0, 5'b00_101, 16'h0001, "ch0 reload snap_h");
        wr(0, 2'd0, 3'd1, 16'h000C);
        rd(0, 5'b00_000, 16'h0002, "ch0 START beats STOP");
        wr(0, 2'd0, 3'd1, 16'h0008);
        rd(0, 5'b00_000, 16'h0000, "ch0 STOP");

        // three-channel instance: out-of-range channel
        wr(1, 2'd3, 3'd2, 16'h1234);
        rd(1, 5'b11_010, 16'h0000, "u3 ch3 reads zero");
        rd(1, 5'b00_010, 16'hC34F, "u3 ch0 unchanged");
        rd(1, 5'b01_010, 16'hC34F, "u3 ch1 unchanged");
        rd(1, 5'b10_010, 16'hC34F, "u3 ch2 unchanged");
        chk("u3 irq", {irq3, irq_vec3}, 4'h0);

        // ch3 prescaler register and timing
`ifdef TIMER_PRESCALER_EN
        wr(0, 2'd3, 3'd6, 16'd2);
        rd(0, 5'b11_110, 16'd2, "ch3 prescale readback");
`else
        wr(0, 2'd3, 3'd6, 16'hFFFF);
        rd(0, 5'b11_110, 16'd0, "ch3 prescale absent");
`endif
        wr(0, 2'd3, 3'd2, 16'd1);
        wr(0, 2'd3, 3'd3, 16'd0);
        wr(0, 2'd3, 3'd1, 16'h0005);
`ifdef TIMER_PRESCALER_EN
        measure_rise(3, 6, "ch3 prescaled timeout latency");
`else
        measure_rise(3, 2, "ch3 timeout latency");
`endif
        chk("ch3 irq", irq, 1'b1);

        // asynchronous reset mid-operation
        @(negedge clk);
        address = 5'b11_000;
        repeat (2) @(negedge clk);
        chk("ch3 status before reset", readdata, 16'h0001);
        #2 reset_n = 1'b0;
        #1;
        chk("readdata cleared by async reset", readdata, 16'h0000);
        chk("irq cleared by async reset", {irq, irq_vec}, 5'h00);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, 5'b11_010, 16'hC34F, "ch3 period after reset");
        rd(0, 5'b00_100, 16'h0000, "ch0 snap after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
